// File: rtl/pb_offset_counter.sv
// Five debounced active-low push buttons drive an up/down/clear counter.
// The registered output is the count added to a live or latched switch base.
module pb_offset_counter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned STEP       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       PB,
    input  logic [WIDTH-1:0] dip_input,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] count,
    output logic             sat_mode,
    output logic             base_hold,
    output logic             evt_pulse
);

    localparam int unsigned NB = 5;
    localparam int unsigned HW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [HW-1:0]    HOLD_MAX = HW'(DEB_CYCLES);
    localparam logic [HW-1:0]    HOLD_ARM = HW'(DEB_CYCLES - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_ARMED   = 2'd2
    } deb_state_e;

    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] rel_c;
    logic [NB-1:0] rel_q;

    // Two-flop synchronizer; idles high so reset looks like "not pressed"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= PB;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_deb
        deb_state_e    state_q, state_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          rel_one_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
            end
        end

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (!sync2_q[i]) begin
                        state_d = ST_PRESSED;
                        hold_d  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (sync2_q[i]) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
                        if (hold_d >= HOLD_ARM) state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (sync2_q[i]) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Event fires on release of a qualified press only
        always_comb begin
            rel_one_c = (state_q == ST_ARMED) && sync2_q[i];
        end

        assign rel_c[i] = rel_one_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rel_q <= '0;
        else        rel_q <= rel_c;
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] latched_base_q, latched_base_d;
    logic             sat_mode_q, sat_mode_d;
    logic             base_hold_q, base_hold_d;
    logic             evt_pulse_q, evt_pulse_d;
    logic [WIDTH:0]   sum_c;

    // Arithmetic uses the pre-edge mode so a same-cycle mode toggle lands afterwards
    always_comb begin
        count_d        = count_q;
        sat_mode_d     = sat_mode_q ^ rel_q[2];
        base_hold_d    = base_hold_q ^ rel_q[4];
        latched_base_d = latched_base_q;
        evt_pulse_d    = |rel_q;
        sum_c          = {1'b0, count_q} + {1'b0, STEP_W};

        if (rel_q[4] && !base_hold_q) latched_base_d = dip_input;

        if (rel_q[0]) begin
            count_d = '0;
        end else if (rel_q[3] && !rel_q[1]) begin
            count_d = (sat_mode_q && sum_c[WIDTH]) ? '1 : sum_c[WIDTH-1:0];
        end else if (rel_q[1] && !rel_q[3]) begin
            count_d = (sat_mode_q && (count_q < STEP_W)) ? '0 : count_q - STEP_W;
        end

        out_d = (base_hold_q ? latched_base_q : dip_input) + count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q        <= '0;
            out_q          <= '0;
            latched_base_q <= '0;
            sat_mode_q     <= 1'b0;
            base_hold_q    <= 1'b0;
            evt_pulse_q    <= 1'b0;
        end else begin
            count_q        <= count_d;
            out_q          <= out_d;
            latched_base_q <= latched_base_d;
            sat_mode_q     <= sat_mode_d;
            base_hold_q    <= base_hold_d;
            evt_pulse_q    <= evt_pulse_d;
        end
    end

    assign count     = count_q;
    assign out       = out_q;
    assign sat_mode  = sat_mode_q;
    assign base_hold = base_hold_q;
    assign evt_pulse = evt_pulse_q;

endmodule

// File: tb/tb_pb_offset_counter.sv
// Directed bench for pb_offset_counter with a short debounce window.
module tb_pb_offset_counter;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [4:0]       PB;
    logic [WIDTH-1:0] dip_input;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] count;
    logic             sat_mode;
    logic             base_hold;
    logic             evt_pulse;

    int n_checks;
    int n_fail;
    int evt_cnt;
    int evt_base;

    pb_offset_counter #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (4),
        .STEP       (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PB        (PB),
        .dip_input (dip_input),
        .out       (out),
        .count     (count),
        .sat_mode  (sat_mode),
        .base_hold (base_hold),
        .evt_pulse (evt_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles, sampled away from the active edge
    initial evt_cnt = 0;
    always @(negedge clk) if (evt_pulse === 1'b1) evt_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold the masked buttons low for low_cycles edges, release, then let it settle
    task automatic press(input logic [4:0] mask, input int low_cycles);
        evt_base = evt_cnt;
        @(posedge clk);
        #1 PB = ~mask;
        repeat (low_cycles) @(posedge clk);
        #1 PB = 5'h1F;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        PB        = 5'h1F;
        dip_input = 16'h0010;
        #1;
        check_val("rst_count", 32'(count), 32'h0);
        check_val("rst_out", 32'(out), 32'h0);
        check_val("rst_sat", 32'(sat_mode), 32'h0);
        check_val("rst_hold", 32'(base_hold), 32'h0);
        check_val("rst_evt", 32'(evt_pulse), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("idle_out", 32'(out), 32'h0010);

        // Qualified increment press
        press(5'b01000, 10);
        check_val("inc_evt", 32'(evt_cnt - evt_base), 32'd1);
        check_val("inc_count", 32'(count), 32'h0001);
        check_val("inc_out", 32'(out), 32'h0011);

        // Too short to qualify
        press(5'b01000, 2);
        check_val("glitch_evt", 32'(evt_cnt - evt_base), 32'd0);
        check_val("glitch_count", 32'(count), 32'h0001);

        // Clear, then wrap below zero
        press(5'b00001, 10);
        check_val("clr_count", 32'(count), 32'h0000);
        press(5'b00010, 10);
        check_val("wrap_dec", 32'(count), 32'hFFFF);
        check_val("wrap_out", 32'(out), 32'h000F);

        // Saturate mode clamps at both ends
        press(5'b00100, 10);
        check_val("sat_on", 32'(sat_mode), 32'h1);
        press(5'b01000, 10);
        check_val("sat_inc1", 32'(count), 32'hFFFF);
        press(5'b01000, 10);
        check_val("sat_inc2", 32'(count), 32'hFFFF);
        press(5'b00001, 10);
        press(5'b00010, 10);
        check_val("sat_dec0", 32'(count), 32'h0000);
        press(5'b00100, 10);
        check_val("sat_off", 32'(sat_mode), 32'h0);

        // Clear beats increment in the same cycle
        for (int k = 0; k < 5; k++) press(5'b01000, 10);
        check_val("count5", 32'(count), 32'h0005);
        press(5'b01001, 10);
        check_val("clr_inc_count", 32'(count), 32'h0000);
        check_val("clr_inc_evt", 32'(evt_cnt - evt_base), 32'd1);

        // Increment with decrement cancels
        press(5'b01000, 10);
        press(5'b01010, 10);
        check_val("inc_dec_count", 32'(count), 32'h0001);
        check_val("inc_dec_evt", 32'(evt_cnt - evt_base), 32'd1);

        // Mode toggle with increment: old (wrap) mode governs the arithmetic
        press(5'b00001, 10);
        press(5'b00010, 10);
        press(5'b01100, 10);
        check_val("toggle_inc_count", 32'(count), 32'h0000);
        check_val("toggle_inc_sat", 32'(sat_mode), 32'h1);
        press(5'b00100, 10);

        // Base latch
        dip_input = 16'h1000;
        press(5'b01000, 10);
        check_val("base_live_out", 32'(out), 32'h1001);
        press(5'b10000, 10);
        check_val("hold_on", 32'(base_hold), 32'h1);
        dip_input = 16'h2000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("hold_out", 32'(out), 32'h1001);
        press(5'b10000, 10);
        check_val("hold_off", 32'(base_hold), 32'h0);
        check_val("unhold_out", 32'(out), 32'h2001);

        // Reset while armed discards the press
        press(5'b01000, 10);
        check_val("pre_rst_count", 32'(count), 32'h0002);
        @(posedge clk);
        #1 PB = 5'b10111;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_count", 32'(count), 32'h0);
        check_val("mid_rst_out", 32'(out), 32'h0);
        check_val("mid_rst_evt", 32'(evt_pulse), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        evt_base = evt_cnt;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_val("held_no_evt", 32'(evt_cnt - evt_base), 32'd0);
        check_val("held_count", 32'(count), 32'h0);
        #1 PB = 5'h1F;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("post_rst_evt", 32'(evt_cnt - evt_base), 32'd1);
        check_val("post_rst_count", 32'(count), 32'h0001);
        check_val("post_rst_out", 32'(out), 32'h2001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
